falu_add_issue_ctrl: RTL and testbench

FALU_ADD_ISSUE_CTRL -- requirements
Module: falu_add_issue_ctrl

---
 rtl/falu_add_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_falu_add_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/falu_add_issue_ctrl.sv
// Issue controller for a shared FP add/sub unit: round-robin arbitration of two
// requesters, an operand stage feeding the adder, and a 2-entry result FIFO.
module falu_add_issue_ctrl #(
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [65:0]      req0_op1,
   input  logic [65:0]      req0_op2,
   input  logic [65:0]      req1_op1,
   input  logic [65:0]      req1_op2,
   input  logic [4:0]       req0_ctl,
   input  logic [4:0]       req1_ctl,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [65:0]      add_in1,
   output logic [65:0]      add_in2,
   output logic [2:0]       add_rm,
   output logic             add_dbl,
   output logic             add_sub,
   input  logic [65:0]      add_result,
   input  logic [3:0]       add_flags,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [65:0]      res_data,
   output logic [3:0]       res_flags,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_src
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high. reqN_ready is a grant and is only ever raised toward a valid requester;
   // res_valid never depends on res_ready, and res_* hold while res_valid && !res_ready.

   typedef struct packed {
      logic [65:0]      data;
      logic [3:0]       flags;
      logic [TAG_W-1:0] tag;
      logic             src;
   } res_ent_t;

   logic             s1_valid;
   logic [65:0]      s1_op1;
   logic [65:0]      s1_op2;
   logic [4:0]       s1_ctl;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_src;

   res_ent_t         fifo_mem [2];
   res_ent_t         head;
   logic [1:0]       fifo_cnt;
   logic             wr_ptr;
   logic             rd_ptr;
   logic             prio;

   logic             pop;
   logic             s1_adv;
   logic             can_issue;
   logic             grant0;
   logic             grant1;

   assign res_valid = (fifo_cnt != 2'd0);
   assign pop       = res_valid && res_ready && !flush;

   // A full FIFO can still take S1 when its head leaves in the same cycle.
   assign s1_adv    = s1_valid && ((fifo_cnt != 2'd2) || (res_valid && res_ready));
   assign can_issue = (!s1_valid || s1_adv) && !flush && !reset;

   assign grant0 = can_issue && req0_valid && (!req1_valid || !prio);
   assign grant1 = can_issue && req1_valid && (!req0_valid ||  prio);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign add_in1 = s1_valid ? s1_op1      : '0;
   assign add_in2 = s1_valid ? s1_op2      : '0;
   assign add_rm  = s1_valid ? s1_ctl[4:2] : '0;
   assign add_dbl = s1_valid && s1_ctl[1];
   assign add_sub = s1_valid && s1_ctl[0];

   assign head      = fifo_mem[rd_ptr];
   assign res_data  = res_valid ? head.data  : '0;
   assign res_flags = res_valid ? head.flags : '0;
   assign res_tag   = res_valid ? head.tag   : '0;
   assign res_src   = res_valid && head.src;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         fifo_cnt <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         prio     <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         fifo_cnt <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
      end else begin
         if (grant0 || grant1)
            s1_valid <= 1'b1;
         else if (s1_adv)
            s1_valid <= 1'b0;
         if (s1_adv)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, s1_adv} - {1'b0, pop};
         if (grant0)
            prio <= 1'b1;
         else if (grant1)
            prio <= 1'b0;
      end
   end

   // Payload registers need no reset: every consumer is gated by a valid bit.
   always_ff @(posedge clk) begin
      if (grant0 || grant1) begin
         s1_op1 <= grant1 ? req1_op1 : req0_op1;
         s1_op2 <= grant1 ? req1_op2 : req0_op2;
         s1_ctl <= grant1 ? req1_ctl : req0_ctl;
         s1_tag <= grant1 ? req1_tag : req0_tag;
         s1_src <= grant1;
      end
      if (s1_adv && !flush && !reset)
         fifo_mem[wr_ptr] <= '{data: add_result, flags: add_flags, tag: s1_tag, src: s1_src};
   end

endmodule

// File: tb/tb_falu_add_issue_ctrl.sv
// Directed bench for falu_add_issue_ctrl with a stand-in combinational adder.
module tb_falu_add_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [65:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [4:0]  req0_ctl, req1_ctl;
   logic [5:0]  req0_tag, req1_tag;
   logic [65:0] add_in1, add_in2;
   logic [2:0]  add_rm;
   logic        add_dbl, add_sub;
   logic [65:0] add_result;
   logic [3:0]  add_flags;
   logic        res_valid, res_ready;
   logic [65:0] res_data;
   logic [3:0]  res_flags;
   logic [5:0]  res_tag;
   logic        res_src;

   int n_assert = 0;
   int n_fail   = 0;

   falu_add_issue_ctrl #(.TAG_W(6)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2),
      .req1_op1(req1_op1), .req1_op2(req1_op2),
      .req0_ctl(req0_ctl), .req1_ctl(req1_ctl),
      .req0_tag(req0_tag), .req1_tag(req1_tag),
      .add_in1(add_in1), .add_in2(add_in2), .add_rm(add_rm),
      .add_dbl(add_dbl), .add_sub(add_sub),
      .add_result(add_result), .add_flags(add_flags),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_flags(res_flags),
      .res_tag(res_tag), .res_src(res_src)
   );

   // Stand-in adder: knows 1.0+2.0 in single precision, otherwise plain integer sum.
   assign add_result = (add_in1 == 66'h3F800000 && add_in2 == 66'h40000000) ?
                       66'h40400000 : add_in1 + add_in2;
   assign add_flags  = {add_sub, add_dbl, add_rm[1:0]};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [65:0] a, input logic [65:0] b,
                         input logic [4:0] c, input logic [5:0] t);
      req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctl = c; req0_tag = t;
   endtask

   task automatic drive1(input logic v, input logic [65:0] a, input logic [65:0] b,
                         input logic [4:0] c, input logic [5:0] t);
      req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctl = c; req1_tag = t;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      res_ready = 1'b1;
      drive0(1'b1, 66'h5, 66'h6, 5'd0, 6'd1);
      drive1(1'b0, 66'h0, 66'h0, 5'd0, 6'd0);

      // Reset state
      @(negedge clk);
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_add_in1", add_in1, 66'h0);
      chk("rst_res_data", res_data, 66'h0);
      chk("rst_res_tag", res_tag, 6'h0);
      next_cycle();
      reset = 1'b0;
      req0_valid = 1'b0;

      // Contention: grants alternate 0,1,0,1,0,1; results return in that order
      for (int k = 0; k < 9; k++) begin
         drive0(k < 6, 66'h100, 66'h1, 5'b01110, 6'd1);
         drive1(k < 6, 66'h200, 66'h2, 5'b00001, 6'd2);
         @(negedge clk);
         if (k < 6) begin
            chk($sformatf("cont_ready0_%0d", k), req0_ready, (k % 2) == 0);
            chk($sformatf("cont_ready1_%0d", k), req1_ready, (k % 2) == 1);
         end
         if (k >= 2 && k < 8) begin
            chk($sformatf("cont_res_valid_%0d", k), res_valid, 1'b1);
            chk($sformatf("cont_res_src_%0d", k), res_src, (k % 2) == 1);
            chk($sformatf("cont_res_tag_%0d", k), res_tag, (k % 2) ? 6'd2 : 6'd1);
            chk($sformatf("cont_res_data_%0d", k), res_data, (k % 2) ? 66'h202 : 66'h101);
            chk($sformatf("cont_res_flags_%0d", k), res_flags, (k % 2) ? 4'h8 : 4'h7);
         end
         if (k == 8)
            chk("cont_drained", res_valid, 1'b0);
         next_cycle();
      end

      // Single op: 1.0 + 2.0 from req0, tag 5
      drive0(1'b1, 66'h3F800000, 66'h40000000, 5'd0, 6'd5);
      @(negedge clk);
      chk("single_ready0", req0_ready, 1'b1);
      chk("single_ready1", req1_ready, 1'b0);
      next_cycle();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("single_add_in1", add_in1, 66'h3F800000);
      chk("single_add_in2", add_in2, 66'h40000000);
      chk("single_res_early", res_valid, 1'b0);
      next_cycle();
      @(negedge clk);
      chk("single_res_valid", res_valid, 1'b1);
      chk("single_res_data", res_data[33:0], 34'h040400000);
      chk("single_res_tag", res_tag, 6'd5);
      chk("single_res_src", res_src, 1'b0);
      chk("single_res_flags", res_flags, 4'h0);
      next_cycle();
      @(negedge clk);
      chk("single_popped", res_valid, 1'b0);
      next_cycle();

      // Backpressure: FIFO fills, S1 holds, ready drops, then all 3 drain in order
      res_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         drive0(1'b1, 66'h1000 + 66'(n), 66'h0, 5'd0, 6'(20 + n));
         @(negedge clk);
         chk($sformatf("bp_ready0_%0d", n), req0_ready, n < 3);
         if (n >= 3) begin
            chk($sformatf("bp_res_tag_%0d", n), res_tag, 6'd20);
            chk($sformatf("bp_s1_hold_%0d", n), add_in1, 66'h1002);
         end
         next_cycle();
      end
      req0_valid = 1'b0;
      res_ready = 1'b1;
      for (int m = 0; m < 3; m++) begin
         @(negedge clk);
         chk($sformatf("bp_drain_valid_%0d", m), res_valid, 1'b1);
         chk($sformatf("bp_drain_tag_%0d", m), res_tag, 6'(20 + m));
         chk($sformatf("bp_drain_data_%0d", m), res_data, 66'h1000 + 66'(m));
         next_cycle();
      end
      @(negedge clk);
      chk("bp_empty", res_valid, 1'b0);
      next_cycle();

      // Full FIFO with simultaneous pop and push keeps count at 2
      res_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         drive0(1'b1, 66'h2000 + 66'(n), 66'h0, 5'd0, 6'(30 + n));
         @(negedge clk);
         chk($sformatf("full_fill_ready_%0d", n), req0_ready, 1'b1);
         next_cycle();
      end
      res_ready = 1'b1;
      drive0(1'b1, 66'h2003, 66'h0, 5'd0, 6'd33);
      @(negedge clk);
      chk("full_pp_ready0", req0_ready, 1'b1);
      chk("full_pp_head", res_tag, 6'd30);
      next_cycle();
      res_ready = 1'b0;
      drive0(1'b1, 66'h2004, 66'h0, 5'd0, 6'd34);
      @(negedge clk);
      chk("full_still2_ready0", req0_ready, 1'b0);
      chk("full_still2_head", res_tag, 6'd31);
      chk("full_s1_new", add_in1, 66'h2003);
      next_cycle();

      // Flush with S1 and both FIFO entries valid; pointer (1) survives
      flush = 1'b1;
      res_ready = 1'b1;
      drive1(1'b1, 66'h3000, 66'h0, 5'd0, 6'd40);
      @(negedge clk);
      chk("flush_ready0", req0_ready, 1'b0);
      chk("flush_ready1", req1_ready, 1'b0);
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_res_valid", res_valid, 1'b0);
      chk("flush_s1_clear", add_in1, 66'h0);
      chk("flush_ptr_ready1", req1_ready, 1'b1);
      chk("flush_ptr_ready0", req0_ready, 1'b0);
      next_cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("flush_no_stale", res_valid, 1'b0);
      next_cycle();
      @(negedge clk);
      chk("flush_new_valid", res_valid, 1'b1);
      chk("flush_new_tag", res_tag, 6'd40);
      chk("flush_new_src", res_src, 1'b1);
      chk("flush_new_data", res_data, 66'h3000);
      next_cycle();
      @(negedge clk);
      chk("flush_after_empty", res_valid, 1'b0);
      next_cycle();

      // Reset mid-operation; pointer is left at 1 before reset
      res_ready = 1'b0;
      drive0(1'b1, 66'h4000, 66'h0, 5'd0, 6'd50);
      @(negedge clk);
      chk("rmid_grant0", req0_ready, 1'b1);
      next_cycle();
      req0_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("rmid_res_valid", res_valid, 1'b1);
      chk("rmid_res_tag", res_tag, 6'd50);
      #2;
      reset = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rmid_async_res_valid", res_valid, 1'b0);
      chk("rmid_async_res_data", res_data, 66'h0);
      chk("rmid_async_ready0", req0_ready, 1'b0);
      chk("rmid_async_ready1", req1_ready, 1'b0);
      next_cycle();
      chk("rmid_hold_add_in1", add_in1, 66'h0);
      chk("rmid_hold_ready0", req0_ready, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("rmid_after_ready0", req0_ready, 1'b1);
      chk("rmid_after_ready1", req1_ready, 1'b0);
      chk("rmid_after_res_valid", res_valid, 1'b0);
      next_cycle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready = 1'b1;
      next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
